// File: rtl/bitcell_pkg.sv
// Types and default geometry shared by the bitcell array read and write sides.
package bitcell_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_DATA_W       = 4;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_SENSE_CYCLES = 2;

  // Sense counter loads SENSE_CYCLES-1 and stops at zero, so this never wraps.
  function automatic int sense_cnt_w(input int sense_cycles);
    return $clog2(sense_cycles) + 1;
  endfunction

endpackage

// File: rtl/bitcell_wl_decoder.sv
// Address to one-hot word-line decode; addresses past the array decode to all-zero.
module bitcell_wl_decoder
  import bitcell_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bitcell_read_ctrl.sv
// Read-side controller: one request at a time, holds a word line for the sense
// time, samples the shared read bus and returns the word over valid/ready.
//
//   state  | meaning
//   IDLE   | ready for a request, word lines off
//   SELECT | word line held (or one dead cycle for a bad address), counting down
//   RESP   | response presented until the consumer takes it
module bitcell_read_ctrl
  import bitcell_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int SENSE_CYCLES = DEF_SENSE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [DEPTH-1:0]  wl_sel,
  input  logic [DATA_W-1:0] rd_bus,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = sense_cnt_w(SENSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SENSE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic [DEPTH-1:0] dec_sel;
  logic             addr_ok;

  bitcell_wl_decoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dec (
    .addr (req_addr),
    .sel  (dec_sel)
  );

  assign addr_ok = |dec_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      wl_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SELECT;
            // A bad address still spends one SELECT cycle, with no word line driven.
            if (addr_ok) begin
              cnt    <= CNT_INIT;
              err_q  <= 1'b0;
              wl_sel <= dec_sel;
            end else begin
              cnt    <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (cnt == '0) begin
            rsp_data  <= err_q ? '0 : rd_bus;
            rsp_err   <= err_q;
            wl_sel    <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitcell_read_ctrl.sv
// Bench for bitcell_read_ctrl: four geometries run side by side, each against a
// transaction-timestamp model, plus directed reads with literal expectations.
module tb_bitcell_read_ctrl;

  logic clk;
  int   errors;
  int   checks;
  int   done_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int DEP = (g == 1) ? 3 : 4;
    localparam int SC  = (g == 2) ? 1 : ((g == 3) ? 4 : 2);

    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_addr;
    logic [DEP-1:0] wl_sel;
    logic [3:0]     rd_bus;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [3:0]     rsp_data;
    logic           rsp_err;
    logic           busy;

    // Model: edge count e, accept edge m_t0, response edge m_rsp_at.
    int e, m_t0, m_rsp_at, m_addr, m_data;
    bit m_busy, m_err;
    logic [3:0] words [4];

    bitcell_read_ctrl #(
      .DATA_W       (4),
      .DEPTH        (DEP),
      .ADDR_W       (2),
      .SENSE_CYCLES (SC)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .wl_sel    (wl_sel),
      .rd_bus    (rd_bus),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
    );

    task automatic model_edge();
      e++;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy   = 1'b1;
          m_t0     = e;
          m_addr   = int'(req_addr);
          m_err    = (m_addr >= DEP);
          m_rsp_at = m_t0 + (m_err ? 1 : SC);
          m_data   = 0;
        end
      end else begin
        if (e == m_rsp_at && !m_err) m_data = int'(rd_bus);
        if (e > m_rsp_at && rsp_ready) m_busy = 1'b0;
      end
    endtask

    task automatic cmp();
      int exp_wl;
      bit exp_rv;
      exp_wl = (m_busy && !m_err && e < m_t0 + SC) ? (1 << m_addr) : 0;
      exp_rv = m_busy && (e >= m_rsp_at);
      chk($sformatf("cfg%0d wl_sel e=%0d", g, e), int'(wl_sel), exp_wl);
      chk($sformatf("cfg%0d rsp_valid e=%0d", g, e), int'(rsp_valid), int'(exp_rv));
      chk($sformatf("cfg%0d req_ready e=%0d", g, e), int'(req_ready), int'(!m_busy));
      chk($sformatf("cfg%0d busy e=%0d", g, e), int'(busy), int'(m_busy));
      chk($sformatf("cfg%0d wl_onehot e=%0d", g, e), int'($countones(wl_sel) <= 1), 1);
      if (exp_rv) begin
        chk($sformatf("cfg%0d rsp_data e=%0d", g, e), int'(rsp_data), m_data);
        chk($sformatf("cfg%0d rsp_err e=%0d", g, e), int'(rsp_err), int'(m_err));
      end
    endtask

    task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      cmp();
    endtask

    task automatic drain();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < SC + 6; k++) step();
      rsp_ready = 1'b0;
    endtask

    initial begin
      int t0, lat, width, nacc, prev_t0, prev_lat;
      words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h5; words[3] = 4'hF;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; rd_bus = '0;
      m_busy = 1'b0; m_err = 1'b0; e = 0; m_t0 = 0; m_rsp_at = 0; m_addr = 0; m_data = 0;

      repeat (2) @(negedge clk);
      chk($sformatf("cfg%0d reset wl_sel", g), int'(wl_sel), 0);
      chk($sformatf("cfg%0d reset rsp_valid", g), int'(rsp_valid), 0);
      chk($sformatf("cfg%0d reset rsp_data", g), int'(rsp_data), 0);
      chk($sformatf("cfg%0d reset rsp_err", g), int'(rsp_err), 0);
      chk($sformatf("cfg%0d reset busy", g), int'(busy), 0);
      rst_n = 1'b1;
      step();

      // Read of word 1; the bus carries the word only in the final sense cycle.
      req_valid = 1'b1; req_addr = 2'd1; rd_bus = 4'b0101;
      step();
      t0 = e; req_valid = 1'b0; lat = -1;
      width = (int'(wl_sel) == 2) ? 1 : 0;
      for (int k = 0; k < SC + 6 && lat < 0; k++) begin
        rd_bus = (e == t0 + SC - 1) ? 4'b1010 : 4'b0101;
        step();
        if (int'(wl_sel) == 2) width++;
        if (rsp_valid) lat = e - t0;
      end
      chk($sformatf("cfg%0d read latency", g), lat, SC);
      chk($sformatf("cfg%0d wl width", g), width, SC);
      chk($sformatf("cfg%0d read data", g), int'(rsp_data), 4'b1010);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      step();

      // Address 3: out of range only for the 3-word geometry.
      req_valid = 1'b1; req_addr = 2'd3;
      step();
      t0 = e; req_valid = 1'b0; lat = -1;
      for (int k = 0; k < SC + 6 && lat < 0; k++) begin
        step();
        if (rsp_valid) lat = e - t0;
      end
      chk($sformatf("cfg%0d addr3 latency", g), lat, (3 >= DEP) ? 1 : SC);
      chk($sformatf("cfg%0d addr3 err", g), int'(rsp_err), int'(3 >= DEP));
      drain();

      // Backpressure with ignored request pulses, then accept after handshake+1.
      req_valid = 1'b1; req_addr = 2'd0; rd_bus = 4'h6;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < SC + 5; k++) begin
        req_valid = k[0];
        req_addr  = 2'd2;
        step();
      end
      req_valid = 1'b1; rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      step();
      step();
      drain();

      // Back-to-back sweep, bus driven by whichever word line is raised.
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 2'd0;
      nacc = 0; prev_t0 = 0; prev_lat = 0;
      for (int k = 0; k < 80 && nacc < 4; k++) begin
        rd_bus = 4'h0;
        for (int i = 0; i < DEP; i++) if (wl_sel[i]) rd_bus = words[i];
        step();
        if (rsp_valid)
          chk($sformatf("cfg%0d sweep data e=%0d", g, e), int'(rsp_data), m_err ? 0 : int'(words[m_addr]));
        if (m_busy && m_t0 == e) begin
          if (nacc > 0)
            chk($sformatf("cfg%0d sweep spacing e=%0d", g, e), e - prev_t0, prev_lat + 2);
          prev_t0 = e; prev_lat = m_err ? 1 : SC;
          nacc++;
          req_addr = 2'(nacc);
        end
      end
      chk($sformatf("cfg%0d sweep accepts", g), nacc, 4);
      drain();

      // Reset in the middle of a read of word 2.
      req_valid = 1'b1; req_addr = 2'd2;
      step();
      req_valid = 1'b0;
      step();
      #2 rst_n = 1'b0;
      m_busy = 1'b0;
      #1;
      chk($sformatf("cfg%0d midreset wl_sel", g), int'(wl_sel), 0);
      chk($sformatf("cfg%0d midreset rsp_valid", g), int'(rsp_valid), 0);
      step();
      step();
      rst_n = 1'b1;
      chk($sformatf("cfg%0d postreset req_ready", g), int'(req_ready), 1);
      chk($sformatf("cfg%0d postreset busy", g), int'(busy), 0);
      for (int k = 0; k < SC + 3; k++) step();

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 2'($urandom_range(0, 3));
        rsp_ready = ($urandom_range(0, 3) != 0);
        rd_bus    = 4'($urandom_range(0, 15));
        step();
      end
      drain();
      done_cnt++;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    done_cnt = 0;
    for (int i = 0; i < 20000 && done_cnt < 4; i++) @(posedge clk);
    chk("all_configs_done", done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
